// File: rtl/ppi_port_array.sv
`default_nettype none
// ============================================================================
//  Module   : ppi_port_array
//  Purpose  : N independent W-bit peripheral ports, each run-time selectable
//             as simple I/O (mode 0) or strobed handshake I/O (mode 1), with
//             per-port interrupt and overrun flags behind a small host bus.
//  Options  : PPI_SYNC_EN - two-flop synchronizers on stb_n/ack_n/pin_in;
//             when undefined a single register stage samples the pins.
//  Revision : 1.0 - initial release
// ============================================================================
module ppi_port_array #(
   parameter int N = 3,
   parameter int W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cs_n,
   input  logic               rd_n,
   input  logic               wr_n,
   input  logic [3:0]         addr,
   input  logic [W-1:0]       din,
   output logic [W-1:0]       dout,
   output logic               dout_oe,
   input  logic [N*W-1:0]     pin_in,
   output logic [N*W-1:0]     pout,
   output logic [N-1:0]       poe,
   input  logic [N-1:0]       stb_n,
   input  logic [N-1:0]       ack_n,
   output logic [N-1:0]       ibf,
   output logic [N-1:0]       obf_n,
   output logic [N-1:0]       intr
);

   localparam logic [3:0] CTRL_ADDR = 4'(N);

   // host bus tracking
   logic             wr_n_q, wr_n_d;
   logic             rd_act_q, rd_act_d;
   logic [3:0]       rd_addr_q, rd_addr_d;
   logic             wr_commit, rd_start, rd_end, ctl_wr;

   // per-port state
   logic [N-1:0]          mode_q, mode_d, dir_q, dir_d, inte_q, inte_d;
   logic [N-1:0]          ibf_q, ibf_d, obf_n_q, obf_n_d, intr_q, intr_d, ovr_q, ovr_d;
   logic [N-1:0][W-1:0]   out_q, out_d, in_q, in_d;
   logic [3:0]            sel_q, sel_d;

   // pin-side sampling
   logic [N-1:0]          stb_src, ack_src;
   logic [N-1:0][W-1:0]   pin_src;
   logic [N-1:0]          stb_s_q, ack_s_q, stb_p_q, ack_p_q;
   logic [N-1:0][W-1:0]   pin_s_q;
   logic [N-1:0]          stb_fall, ack_rise, rd_port, wr_port, ctl_hit;
   logic [3:0]            stat;

`ifdef PPI_SYNC_EN
   logic [N-1:0]          stb_m_q, ack_m_q;
   logic [N-1:0][W-1:0]   pin_m_q;

   // first synchronizer stage for asynchronous pin inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         stb_m_q <= '1;
         ack_m_q <= '1;
         pin_m_q <= '0;
      end else begin
         stb_m_q <= stb_n;
         ack_m_q <= ack_n;
         pin_m_q <= pin_in;
      end
   end
   assign stb_src = stb_m_q;
   assign ack_src = ack_m_q;
   assign pin_src = pin_m_q;
`else
   assign stb_src = stb_n;
   assign ack_src = ack_n;
   assign pin_src = pin_in;
`endif

   // final pin sample stage plus one-cycle history for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         stb_s_q <= '1;
         ack_s_q <= '1;
         stb_p_q <= '1;
         ack_p_q <= '1;
         pin_s_q <= '0;
      end else begin
         stb_s_q <= stb_src;
         ack_s_q <= ack_src;
         stb_p_q <= stb_s_q;
         ack_p_q <= ack_s_q;
         pin_s_q <= pin_src;
      end
   end

   assign wr_commit = !cs_n && !wr_n && wr_n_q;
   assign rd_start  = !cs_n && !rd_n && !rd_act_q;
   assign rd_end    = rd_n && rd_act_q;
   assign ctl_wr    = wr_commit && (addr == CTRL_ADDR) && (din[3:0] < CTRL_ADDR);

   for (genvar i = 0; i < N; i++) begin : g_port
      assign stb_fall[i] = stb_p_q[i] & ~stb_s_q[i];
      assign ack_rise[i] = ~ack_p_q[i] & ack_s_q[i];
      assign rd_port[i]  = rd_end && (rd_addr_q == 4'(i));
      assign wr_port[i]  = wr_commit && (addr == 4'(i)) && !dir_q[i];
      assign ctl_hit[i]  = ctl_wr && (din[3:0] == 4'(i));
   end

   // next-state for bus tracking and all port handshakes
   always_comb begin
      wr_n_d    = wr_n;
      rd_act_d  = !cs_n && !rd_n;
      rd_addr_d = rd_start ? addr : rd_addr_q;
      mode_d    = mode_q;
      dir_d     = dir_q;
      inte_d    = inte_q;
      ibf_d     = ibf_q;
      obf_n_d   = obf_n_q;
      intr_d    = intr_q;
      ovr_d     = ovr_q;
      out_d     = out_q;
      in_d      = in_q;
      sel_d     = sel_q;
      for (int i = 0; i < N; i++) begin
         if (rd_end && (rd_addr_q == CTRL_ADDR) && (sel_q == 4'(i)))
            ovr_d[i] = 1'b0;
         if (mode_q[i]) begin
            if (dir_q[i]) begin
               // a strobe landing on the read-end cycle refills the emptied buffer
               if (rd_port[i])
                  ibf_d[i] = 1'b0;
               if (stb_fall[i]) begin
                  if (!ibf_d[i]) begin
                     in_d[i]  = pin_s_q[i];
                     ibf_d[i] = 1'b1;
                  end else begin
                     ovr_d[i] = 1'b1;
                  end
               end
               intr_d[i] = inte_q[i] & ibf_d[i] & stb_s_q[i];
            end else begin
               // a host write takes priority over a concurrent acknowledge
               if (wr_port[i]) begin
                  out_d[i]   = din;
                  obf_n_d[i] = 1'b0;
                  intr_d[i]  = 1'b0;
               end else begin
                  if (!ack_s_q[i])
                     obf_n_d[i] = 1'b1;
                  if (ack_rise[i])
                     intr_d[i] = inte_q[i];
               end
            end
         end else if (wr_port[i]) begin
            out_d[i] = din;
         end
         // control word overrides everything, aborting any handshake
         if (ctl_hit[i]) begin
            inte_d[i] = din[4];
            if (din[7]) begin
               mode_d[i]  = din[6];
               dir_d[i]   = din[5];
               out_d[i]   = '0;
               ibf_d[i]   = 1'b0;
               obf_n_d[i] = 1'b1;
               intr_d[i]  = 1'b0;
               ovr_d[i]   = 1'b0;
            end
         end
      end
      if (ctl_wr)
         sel_d = din[3:0];
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_n_q    <= 1'b1;
         rd_act_q  <= 1'b0;
         rd_addr_q <= '0;
         mode_q    <= '0;
         dir_q     <= '1;
         inte_q    <= '0;
         ibf_q     <= '0;
         obf_n_q   <= '1;
         intr_q    <= '0;
         ovr_q     <= '0;
         out_q     <= '0;
         in_q      <= '0;
         sel_q     <= '0;
      end else begin
         wr_n_q    <= wr_n_d;
         rd_act_q  <= rd_act_d;
         rd_addr_q <= rd_addr_d;
         mode_q    <= mode_d;
         dir_q     <= dir_d;
         inte_q    <= inte_d;
         ibf_q     <= ibf_d;
         obf_n_q   <= obf_n_d;
         intr_q    <= intr_d;
         ovr_q     <= ovr_d;
         out_q     <= out_d;
         in_q      <= in_d;
         sel_q     <= sel_d;
      end
   end

   // host read mux: port data or status of the selected port
   always_comb begin
      stat = '0;
      dout = '0;
      for (int i = 0; i < N; i++) begin
         if (sel_q == 4'(i))
            stat = {ovr_q[i], inte_q[i], intr_q[i], dir_q[i] ? ibf_q[i] : ~obf_n_q[i]};
         if (addr == 4'(i))
            dout = !dir_q[i] ? out_q[i] : (mode_q[i] ? in_q[i] : pin_s_q[i]);
      end
      if (addr == CTRL_ADDR)
         dout = {{(W-4){1'b0}}, stat};
   end

   assign dout_oe = !cs_n && !rd_n && (addr <= CTRL_ADDR);
   assign pout    = out_q;
   assign poe     = ~dir_q;
   assign ibf     = ibf_q;
   assign obf_n   = obf_n_q;
   assign intr    = intr_q;

endmodule
`default_nettype wire

// File: tb/tb_ppi_port_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ppi_port_array
//  Purpose  : directed self-checking bench for ppi_port_array (N=3, W=8)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ppi_port_array;
   localparam int N = 3;
   localparam int W = 8;
`ifdef PPI_SYNC_EN
   localparam int S = 2;
`else
   localparam int S = 1;
`endif

   logic             clk = 1'b0;
   logic             reset, cs_n, rd_n, wr_n;
   logic [3:0]       addr;
   logic [W-1:0]     din, dout, rdata;
   logic             dout_oe;
   logic [N*W-1:0]   pin_in, pout;
   logic [N-1:0]     poe, stb_n, ack_n, ibf, obf_n, intr;
   int               checks = 0;
   int               errors = 0;

   ppi_port_array #(.N(N), .W(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .cs_n    (cs_n),
      .rd_n    (rd_n),
      .wr_n    (wr_n),
      .addr    (addr),
      .din     (din),
      .dout    (dout),
      .dout_oe (dout_oe),
      .pin_in  (pin_in),
      .pout    (pout),
      .poe     (poe),
      .stb_n   (stb_n),
      .ack_n   (ack_n),
      .ibf     (ibf),
      .obf_n   (obf_n),
      .intr    (intr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // returns #1 after the commit edge
   task automatic bus_write(input logic [3:0] a, input logic [W-1:0] d);
      @(posedge clk); #1;
      addr = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
      @(posedge clk); #1;
      wr_n = 1'b1; cs_n = 1'b1;
   endtask

   // returns #1 after the read-end edge
   task automatic bus_read(input logic [3:0] a, output logic [W-1:0] d);
      @(posedge clk); #1;
      addr = a; cs_n = 1'b0; rd_n = 1'b0;
      @(posedge clk); #1;
      d = dout;
      rd_n = 1'b1; cs_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic strobe0();
      stb_n[0] = 1'b0;
      idle(2);
      stb_n[0] = 1'b1;
      idle(S + 2);
   endtask

   initial begin
      reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      addr = '0; din = '0;
      pin_in = {8'h00, 8'hA5, 8'h00};
      stb_n = '1; ack_n = '1;
      idle(3);
      reset = 1'b0;
      check("rst_poe",   poe,   3'b000);
      check("rst_obf_n", obf_n, 3'b111);
      check("rst_intr",  intr,  3'b000);
      check("rst_ibf",   ibf,   3'b000);
      check("rst_pout",  pout,  24'h0);
      idle(2);
      bus_read(4'd0, rdata); check("m0_rd0", rdata, 8'h00);
      bus_read(4'd1, rdata); check("m0_rd1", rdata, 8'hA5);
      bus_read(4'd2, rdata); check("m0_rd2", rdata, 8'h00);

      // port1 strobed output, INTE off
      bus_write(4'd3, 8'hC1);
      check("c1_poe", poe, 3'b010);
      check("c1_obf", obf_n, 3'b111);
      bus_write(4'd1, 8'h3C);
      check("wr_pout1", pout[15:8], 8'h3C);
      check("wr_obf",   obf_n, 3'b101);
      ack_n[1] = 1'b0;
      idle(S);
      check("ack_lat_obf", obf_n, 3'b101);
      idle(1);
      check("ack_obf", obf_n, 3'b111);
      ack_n[1] = 1'b1;
      idle(S + 2);
      check("ack_intr", intr, 3'b000);

      // port0 strobed input, INTE on
      bus_write(4'd3, 8'hF0);
      check("f0_poe", poe, 3'b010);
      pin_in[7:0] = 8'h5A;
      idle(S + 1);
      stb_n[0] = 1'b0;
      idle(2);
      stb_n[0] = 1'b1;
      idle(S);
      check("stb_ibf", ibf, 3'b001);
      check("stb_intr_lat", intr, 3'b000);
      idle(1);
      check("stb_intr", intr, 3'b001);
      bus_read(4'd0, rdata);
      check("stb_data", rdata, 8'h5A);
      check("rd_ibf_clr",  ibf,  3'b000);
      check("rd_intr_clr", intr, 3'b000);

      // overrun: second strobe without a read is dropped
      pin_in[7:0] = 8'h11;
      strobe0();
      pin_in[7:0] = 8'h22;
      strobe0();
      bus_read(4'd0, rdata); check("ovr_data", rdata, 8'h11);
      bus_read(4'd3, rdata); check("ovr_stat1", rdata, 8'h0C);
      bus_read(4'd3, rdata); check("ovr_stat2", rdata, 8'h04);

      // write commit coincident with ack low: write wins
      ack_n[1] = 1'b0;
      idle(S + 1);
      bus_write(4'd1, 8'h77);
      check("race_obf",  obf_n, 3'b101);
      check("race_pout", pout[15:8], 8'h77);
      idle(1);
      check("race_ack_obf", obf_n, 3'b111);
      ack_n[1] = 1'b1;
      idle(S + 2);
      bus_write(4'd1, 8'h99);
      check("hs_obf", obf_n, 3'b101);
      bus_write(4'd3, 8'hC1);
      check("abort_obf",  obf_n, 3'b111);
      check("abort_pout", pout[15:8], 8'h00);

      // INTE words and out-of-range port index
      bus_write(4'd3, 8'h11);
      bus_read(4'd3, rdata); check("inte1_stat", rdata, 8'h04);
      bus_write(4'd3, 8'hFF);
      bus_read(4'd3, rdata); check("ff_stat", rdata, 8'h04);
      check("ff_poe", poe, 3'b010);
      bus_write(4'd3, 8'h01);
      bus_read(4'd3, rdata); check("inte0_stat", rdata, 8'h00);
      bus_write(4'd3, 8'h12);
      bus_read(4'd3, rdata); check("inte2_stat", rdata, 8'h04);

      // ignored writes and output-enable decode
      bus_write(4'd0, 8'hEE);
      check("wr_in_ign", pout, 24'h0);
      bus_write(4'd5, 8'hEE);
      check("wr_hi_ign", pout, 24'h0);
      @(posedge clk); #1;
      addr = 4'd5; cs_n = 1'b0; rd_n = 1'b0;
      #1 check("oe_hi", dout_oe, 1'b0);
      addr = 4'd3;
      #1 check("oe_ctl", dout_oe, 1'b1);
      rd_n = 1'b1; cs_n = 1'b1;

      // reset during a handshake
      bus_write(4'd1, 8'h55);
      check("pre_rst_obf", obf_n, 3'b101);
      reset = 1'b1;
      idle(1);
      check("hs_rst_obf",  obf_n, 3'b111);
      check("hs_rst_pout", pout,  24'h0);
      check("hs_rst_poe",  poe,   3'b000);
      reset = 1'b0;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ppi_port_array.md
# ppi_port_array

Parametrised peripheral-interface controller: N independent W-bit ports, each programmable at run time as simple I/O (mode 0) or strobed-handshake I/O (mode 1). It provides per-port interrupts and overrun detection. It is the successor to the fixed three-port 8255-style control logic and sits between the host bus (cs_n/rd_n/wr_n/addr/din/dout) and the external port pins. All state is held in the clk domain.

## Interface
- N, 3, number of ports (1..15)
- W, 8, port and bus width (>= 8)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  reset, synchronous, active-high
- cs_n  input  1  chip select, active-low
- rd_n  input  1  read strobe, active-low level
- wr_n  input  1  write strobe, active-low level
- addr  input  4  0..N-1 = port data; N = control/status; others ignored
- din  input  W  host write data
- dout  output  W  host read data, combinational mux of registered state
- dout_oe  output  1  = !cs_n & !rd_n & (addr <= N)
- pin_in  input  N*W  port pin inputs, port i at [i*W +: W]
- pout  output  N*W  port output registers
- poe  output  N  per-port pin drive enable
- stb_n  input  N  mode-1 input strobe, active-low
- ack_n  input  N  mode-1 output acknowledge, active-low
- ibf  output  N  input buffer full
- obf_n  output  N  output buffer full, active-low
- intr  output  N  per-port interrupt request

## Operation
- Write commit: on the first cycle with cs_n=0, wr_n=0 and wr_n=1 in the previous cycle. din is sampled in that cycle.
- Read end: on the first cycle with rd_n=1 while rd_n=0 and cs_n=0 in the previous cycle. Read side effects are applied then, using addr sampled at read start.
- Control write (addr=N), din[7]=1, mode word:
  - din[6] selects mode (0 simple, 1 strobed).
  - din[5] selects direction (1 input, 0 output).
  - din[4] sets INTE.
  - din[3:0] selects the port. A port index >= N is ignored.
  - Effect on the selected port: out reg=0, ibf=0, obf_n=1, intr=0, ovr=0. The port index is also stored in sel.
- Control write, din[7]=0: INTE of port din[3:0] is set to din[4]. sel is updated. Nothing else changes.
- Status read (addr=N): dout = {0…, ovr, inte, intr, flag} of port sel, where flag = ibf for input and ~obf_n for output. The read end clears ovr of port sel.
- Mode 0 input: poe=0. Reading the port returns the sampled pin_in.
- Mode 0 output: poe=1. A write loads the out reg. A read returns the out reg.
- Mode 1 input: poe=0.
  - A stb_n falling edge with ibf=0 latches pin_in and sets ibf=1.
  - A stb_n falling edge with ibf=1 drops the data and sets ovr=1.
  - intr = inte & ibf & stb_n(sampled high).
  - The read end of the port clears ibf and intr.
- Mode 1 output: poe=1.
  - A write loads the out reg, drives obf_n=0 and clears intr.
  - ack_n sampled low drives obf_n=1.
  - An ack_n rising edge sets intr=inte.
- Simultaneous events:
  - Read end and a new strobe in the same cycle: latch the new data, ibf=1, no ovr.
  - Write commit and ack_n low in the same cycle: the write wins, obf_n=0.
  - A mode word during a handshake aborts it, with the reset values listed above.
- Writes to an input port are ignored. Writes to addr > N are ignored.

## Timing
- Reset values:
  - all ports mode 0 input
  - poe=0, pout=0, ibf=0, obf_n=1 (all), intr=0
  - INTE=0, ovr=0, sel=0
  - Reset during any handshake returns to these values on the next edge.
- Control/data write to output: pout/poe/obf_n update at the edge that commits the write (1 cycle).
- Pin-side sampling of stb_n, ack_n and pin_in passes through S register stages before edge detection:
  - S=2 with the synchronizer (see Configuration), S=1 without.
  - Latency from a pin edge to ibf/obf_n/intr = S+1 cycles.
- dout follows addr/state combinationally; it is valid while dout_oe=1.

## Configuration
- PPI_SYNC_EN defined: two-flop synchronizers on stb_n, ack_n and pin_in (S=2).
- PPI_SYNC_EN undefined: a single register stage (S=1). Pin inputs must then be clk-synchronous.
- Host-bus timing is identical in both builds.

## Test plan
- Reset, then read addr 0..2 with pin_in port1=8'hA5 -> dout 8'hA5 at addr 1; poe=3'b000, obf_n=3'b111, intr=0.
- Mode word 8'hC1 (port1, mode 1, output, INTE=0) then write 8'h3C to addr 1 -> pout port1=8'h3C, obf_n[1]=0. Pulse ack_n[1] low -> obf_n[1]=1, intr[1]=0.
- Mode word 8'hF0 (port0, strobed input, INTE=1); pin_in=8'h5A; stb_n[0] low 2 cycles then high -> ibf[0]=1, then intr[0]=1 S+1 cycles after stb_n high. Read addr 0 -> 8'h5A; ibf[0]=0 and intr[0]=0 after the read end.
- Port0 as above: two strobes without a read, first 8'h11 then 8'h22 -> port read returns 8'h11; status read returns bit3=1 (ovr); a second status read returns bit3=0.
- Port1 mode-1 output: write commit and ack_n[1] low in the same cycle -> obf_n[1]=0. Mode word to port1 mid-handshake -> obf_n[1]=1, pout port1=0.
- Control word 8'hFF (port 15 >= N) -> no state change; INTE word 8'h12 -> INTE[2]=1 and status bit2=1 with sel=2.
